// File: rtl/gshare_branch_predictor_pkg.sv
// Shared types and helpers for the gshare direction predictor.
// Holds the predictor FSM states, the branch outcome type and the counter reset value.
package gshare_branch_predictor_pkg;

    typedef enum logic {
        PRED_INIT = 1'b0,
        PRED_RUN  = 1'b1
    } predictor_state_t;

    typedef enum logic {
        BRANCH_NOT_TAKEN = 1'b0,
        BRANCH_TAKEN     = 1'b1
    } branch_outcome_t;

    // Weakly-not-taken: the largest value whose MSB is still clear.
    function automatic int unsigned ctr_init(input int unsigned ctr_bits);
        return (32'd1 << (ctr_bits - 1)) - 32'd1;
    endfunction

    function automatic branch_outcome_t to_branch_outcome(input logic taken);
        return taken ? BRANCH_TAKEN : BRANCH_NOT_TAKEN;
    endfunction

endpackage

// File: rtl/gshare_branch_predictor_if.sv
// Prediction and resolution signals between the core pipeline (master)
// and the gshare predictor (slave).
interface gshare_branch_predictor_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  pred_valid;
    logic [ADDR_WIDTH-1:0] pred_pc;
    logic                  pred_taken;
    logic                  ready;
    logic                  res_valid;
    logic                  res_taken;
    logic                  res_mispredict;
    logic                  squash;

    modport master (
        output pred_valid, pred_pc, res_valid, res_taken, res_mispredict, squash,
        input  pred_taken, ready
    );

    modport slave (
        input  pred_valid, pred_pc, res_valid, res_taken, res_mispredict, squash,
        output pred_taken, ready
    );
endinterface

// File: rtl/gshare_branch_predictor_fifo.sv
// In-order FIFO of pattern-table indices for predicted-but-unresolved branches.
// Pointers wrap modulo DEPTH; full/empty derive from the occupancy counter.
module bp_index_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         clear,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Slot payloads need no reset: a slot is only read after it was written.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (do_push && (wr_ptr_q == PTR_W'(gi))) begin
                mem_q[gi] <= push_data;
            end
        end
    end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor: PC/GHR-hashed table of saturating counters trained in order.
// Optional statistics counters enabled by defining BRANCH_PREDICTOR_STATS_EN.
module gshare_branch_predictor
    import gshare_branch_predictor_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int INDEX_BITS     = 10,
    parameter int HIST_BITS      = 10,
    parameter int CTR_BITS       = 2,
    parameter int INFLIGHT_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    gshare_branch_predictor_if.slave            bus,
    output logic                                overflow,
    output logic [$clog2(INFLIGHT_DEPTH+1)-1:0] inflight_count,
    output logic [31:0]                         stat_predictions,
    output logic [31:0]                         stat_mispredicts
);
    localparam int TABLE_DEPTH = 1 << INDEX_BITS;
    localparam int CNT_W       = $clog2(INFLIGHT_DEPTH + 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_WNT  = CTR_BITS'(ctr_init(CTR_BITS));

    logic [CTR_BITS-1:0]   table_mem [TABLE_DEPTH];

    predictor_state_t      state_q, state_d;
    logic [INDEX_BITS-1:0] init_idx_q, init_idx_d;
    logic [HIST_BITS-1:0]  ghr_q, ghr_d;
    logic                  overflow_q, overflow_d;

    logic                  is_run;
    logic [INDEX_BITS-1:0] pred_idx;
    logic [HIST_BITS:0]    ghr_shift;
    logic                  mispredict_flush;
    logic                  push_accept, fifo_push, fifo_pop, fifo_clear;
    logic [INDEX_BITS-1:0] fifo_head;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full, fifo_empty;
    logic [CTR_BITS-1:0]   train_ctr, train_ctr_next;
    logic                  tbl_we;
    logic [INDEX_BITS-1:0] tbl_waddr;
    logic [CTR_BITS-1:0]   tbl_wdata;

    assign is_run           = (state_q == PRED_RUN);
    assign pred_idx         = bus.pred_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_q);
    assign ghr_shift        = {ghr_q, bus.res_taken};
    assign mispredict_flush = bus.res_valid & bus.res_mispredict;

    // A wrong-path or flushed push still counts as a delivered prediction.
    assign push_accept = is_run & bus.pred_valid & ~fifo_full;
    assign fifo_push   = push_accept & ~mispredict_flush & ~bus.squash;
    assign fifo_pop    = is_run & bus.res_valid & ~fifo_empty;
    assign fifo_clear  = is_run & (bus.squash | mispredict_flush);

    bp_index_fifo #(
        .WIDTH (INDEX_BITS),
        .DEPTH (INFLIGHT_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (pred_idx),
        .pop       (fifo_pop),
        .clear     (fifo_clear),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Prediction reads the table before any same-cycle training write lands.
    assign bus.pred_taken = rst_n & is_run & ~fifo_full & table_mem[pred_idx][CTR_BITS-1];
    assign bus.ready      = rst_n & is_run & ~fifo_full;
    assign overflow       = overflow_q;
    assign inflight_count = fifo_count;

    assign train_ctr = table_mem[fifo_head];
    always_comb begin
        train_ctr_next = train_ctr;
        if (bus.res_taken) begin
            if (train_ctr != CTR_MAX) train_ctr_next = train_ctr + 1'b1;
        end else begin
            if (train_ctr != '0) train_ctr_next = train_ctr - 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        ghr_d      = ghr_q;
        overflow_d = overflow_q;
        tbl_we     = 1'b0;
        tbl_waddr  = fifo_head;
        tbl_wdata  = train_ctr_next;
        case (state_q)
            PRED_INIT: begin
                tbl_we     = 1'b1;
                tbl_waddr  = init_idx_q;
                tbl_wdata  = CTR_WNT;
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == '1) state_d = PRED_RUN;
            end
            PRED_RUN: begin
                tbl_we = fifo_pop;
                if (bus.res_valid) ghr_d = ghr_shift[HIST_BITS-1:0];
                if (bus.pred_valid && fifo_full) overflow_d = 1'b1;
            end
            default: state_d = PRED_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= PRED_INIT;
            init_idx_q <= '0;
            ghr_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            ghr_q      <= ghr_d;
            overflow_q <= overflow_d;
        end
    end

    // Table contents are rebuilt by the INIT sweep, so the array itself has no reset.
    always_ff @(posedge clk) begin
        if (rst_n && tbl_we) begin
            table_mem[tbl_waddr] <= tbl_wdata;
        end
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] stat_pred_q, stat_pred_d;
    logic [31:0] stat_misp_q, stat_misp_d;

    always_comb begin
        stat_pred_d = stat_pred_q + 32'(push_accept);
        stat_misp_d = stat_misp_q + 32'(is_run & mispredict_flush);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_pred_q <= '0;
            stat_misp_q <= '0;
        end else begin
            stat_pred_q <= stat_pred_d;
            stat_misp_q <= stat_misp_d;
        end
    end

    assign stat_predictions = stat_pred_q;
    assign stat_mispredicts = stat_misp_q;
`else
    assign stat_predictions = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Scoreboard bench for gshare_branch_predictor: directed scenarios then random traffic,
// checked every cycle against an array/queue model of the predictor rules.
module tb_gshare_branch_predictor;
    localparam int AW = 32;
    localparam int IB = 4;
    localparam int HB = 2;
    localparam int CB = 2;
    localparam int D  = 4;
    localparam int TBL   = 1 << IB;
    localparam int CMAX  = (1 << CB) - 1;
    localparam int CINIT = (1 << (CB - 1)) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        overflow;
    logic [2:0]  inflight_count;
    logic [31:0] stat_predictions;
    logic [31:0] stat_mispredicts;

    always #5 clk = ~clk;

    gshare_branch_predictor_if #(.ADDR_WIDTH(AW)) bus ();

    gshare_branch_predictor #(
        .ADDR_WIDTH     (AW),
        .INDEX_BITS     (IB),
        .HIST_BITS      (HB),
        .CTR_BITS       (CB),
        .INFLIGHT_DEPTH (D)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus),
        .overflow         (overflow),
        .inflight_count   (inflight_count),
        .stat_predictions (stat_predictions),
        .stat_mispredicts (stat_mispredicts)
    );

    typedef struct {
        int cyc;
        bit in_reset;
        bit ready;
        bit taken;
        int count;
        bit ovf;
        int sp;
        int sm;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int ctr [TBL];
    int ghr;
    int inflight[$];
    int init_left;
    bit ovf_m;
    int sp_m, sm_m;
    int cyc = 0;

    task automatic check(input string name, input int cyc_no, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc_no, got, want);
        end
    endtask

    task automatic step(input bit rn, input bit pv, input logic [31:0] pc,
                        input bit rv, input bit rt, input bit rm, input bit sq);
        exp_t e;
        int   idx;
        bit   full;
        bit   push_ok;
        rst_n              = rn;
        bus.pred_valid     = pv;
        bus.pred_pc        = pc;
        bus.res_valid      = rv;
        bus.res_taken      = rt;
        bus.res_mispredict = rm;
        bus.squash         = sq;

        idx  = ((pc >> 2) % TBL) ^ ghr;
        full = (inflight.size() == D);
        e.cyc      = cyc;
        e.in_reset = !rn;
        e.count    = inflight.size();
        e.ovf      = ovf_m;
        e.sp       = sp_m;
        e.sm       = sm_m;
        if (!rn || init_left > 0) begin
            e.ready = 1'b0;
            e.taken = 1'b0;
        end else begin
            e.ready = !full;
            e.taken = !full && (ctr[idx] > CINIT);
        end
        exp_q.push_back(e);

        if (!rn) begin
            for (int i = 0; i < TBL; i++) ctr[i] = CINIT;
            ghr = 0;
            inflight.delete();
            init_left = TBL;
            ovf_m = 1'b0;
            sp_m = 0;
            sm_m = 0;
        end else if (init_left > 0) begin
            init_left--;
        end else begin
            push_ok = pv && !full;
            if (push_ok) sp_m++;
            if (pv && full) ovf_m = 1'b1;
            if (rv) begin
                if (inflight.size() > 0) begin
                    int j;
                    j = inflight.pop_front();
                    if (rt) ctr[j] = (ctr[j] < CMAX) ? ctr[j] + 1 : CMAX;
                    else    ctr[j] = (ctr[j] > 0) ? ctr[j] - 1 : 0;
                end
                ghr = ((ghr << 1) | int'(rt)) % (1 << HB);
                if (rm) sm_m++;
            end
            if (sq || (rv && rm)) inflight.delete();
            else if (push_ok) inflight.push_back(idx);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 32'h100, 0, 0, 0, 0);
    endtask

    // Monitor: the DUT presents its outputs every cycle; compare mid-cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ready", e.cyc, int'(bus.ready), int'(e.ready));
                check("pred_taken", e.cyc, int'(bus.pred_taken), int'(e.taken));
                if (!e.in_reset) begin
                    check("inflight_count", e.cyc, int'(inflight_count), e.count);
                    check("overflow", e.cyc, int'(overflow), int'(e.ovf));
`ifdef BRANCH_PREDICTOR_STATS_EN
                    check("stat_predictions", e.cyc, int'(stat_predictions), e.sp);
                    check("stat_mispredicts", e.cyc, int'(stat_mispredicts), e.sm);
`else
                    check("stat_predictions", e.cyc, int'(stat_predictions), 0);
                    check("stat_mispredicts", e.cyc, int'(stat_mispredicts), 0);
`endif
                end
            end
        end
    end

    initial begin : driver
        rst_n = 1'b0;
        bus.pred_valid = 0; bus.pred_pc = '0; bus.res_valid = 0;
        bus.res_taken = 0; bus.res_mispredict = 0; bus.squash = 0;
        init_left = TBL; ghr = 0; ovf_m = 0; sp_m = 0; sm_m = 0;
        for (int i = 0; i < TBL; i++) ctr[i] = CINIT;
        @(posedge clk);
        #1;

        // Reset and INIT sweep, then first RUN cycle
        step(0, 0, 32'h100, 0, 0, 0, 0);
        idle(TBL + 1);

        // Training: four predict/resolve-taken pairs on pc 0x100
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 32'h100, 0, 0, 0, 0);
            step(1, 0, 32'h100, 1, 1, 0, 0);
        end
        // Saturation: five more taken, one not-taken
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 32'h100, 0, 0, 0, 0);
            step(1, 0, 32'h100, 1, 1, 0, 0);
        end
        step(1, 1, 32'h100, 0, 0, 0, 0);
        step(1, 0, 32'h100, 1, 0, 0, 0);
        step(1, 1, 32'h100, 0, 0, 0, 0);
        step(1, 0, 32'h100, 1, 1, 0, 0);

        // Full FIFO and overflow
        for (int i = 0; i < 5; i++) step(1, 1, 32'h100 + 32'(i * 4), 0, 0, 0, 0);
        idle(1);
        step(1, 0, 32'h100, 0, 0, 0, 1);

        // Mispredict with same-cycle push, then resolve on empty FIFO
        for (int i = 0; i < 3; i++) step(1, 1, 32'h104, 0, 0, 0, 0);
        step(1, 1, 32'h108, 1, 1, 1, 0);
        idle(1);
        step(1, 0, 32'h100, 1, 1, 0, 0);
        step(1, 1, 32'h100, 0, 0, 0, 0);
        idle(1);

        // Random traffic with occasional squash and reset
        for (int i = 0; i < 3000; i++) begin
            bit rn, pv, rv, rt, rm, sq;
            logic [31:0] pc;
            rn = ($urandom_range(0, 999) >= 3);
            pv = ($urandom_range(0, 1) == 1);
            pc = 32'h400 + 32'($urandom_range(0, 31) * 4);
            rv = ($urandom_range(0, 9) < 4);
            rt = ($urandom_range(0, 1) == 1);
            rm = rv && ($urandom_range(0, 9) < 2);
            sq = ($urandom_range(0, 99) < 3);
            step(rn, pv, pc, rv, rt, rm, sq);
        end
        idle(2);

        @(negedge clk);
        #1;
        check("scoreboard_drained", cyc, exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
